seq_stepper: RTL and testbench

Controller that sequences the seq_top pattern detector without push-buttons. It captures a bit pattern and length, clears the detector, and feeds the bits one at a time on the detector's in/next inputs. After each step it samples the detector's out and state_display, and reports hit statistics and lock-up. It sits between a host or test register block and one seq_top instance.

---
 rtl/seq_stepper.sv | 194 +++++++++++++++++++
 tb/tb_seq_stepper.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_stepper.sv
// seq_stepper: drives a seq_top pattern detector one bit at a time.
// It captures a pattern and length on start, clears the detector, then
// for every bit issues one det_next strobe, waits GAP cycles, and samples
// the detector's out/state_display. It reports hit statistics and whether
// the run was aborted because the detector reached its lock-up state.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 1-cycle run request, ignored unless idle
//   pattern [MAX_LEN]     bits to send, bit len-1 first, bit 0 last
//   len [4]               bit count, clamped to MAX_LEN
//   det_state [3], det_out  detector state_display and out
//   det_reset, det_in, det_next  detector reset, data bit, step strobe
//   busy, done            FSM not idle / 1-cycle end-of-run pulse
//   hit, hit_idx [4], hit_count [4], locked  results of the last run
module seq_stepper #(
  parameter int         MAX_LEN   = 8,
  parameter int         GAP       = 2,
  parameter logic [2:0] LOCK_CODE = 3'd6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [3:0]         len,
  input  logic [2:0]         det_state,
  input  logic               det_out,
  output logic               det_reset,
  output logic               det_in,
  output logic               det_next,
  output logic               busy,
  output logic               done,
  output logic               hit,
  output logic [3:0]         hit_idx,
  output logic [3:0]         hit_count,
  output logic               locked
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_DRIVE  = 3'd2,
    S_WAIT   = 3'd3,
    S_SAMPLE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [3:0] MAX_LEN4 = 4'(MAX_LEN);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  state_t             state;
  state_t             state_nx;
  logic [7:0]         cnt;
  logic [MAX_LEN-1:0] pat;      // MSB is always the bit currently being sent
  logic [3:0]         len_q;
  logic [3:0]         k;
  logic [3:0]         len_c;
  logic               load;
  logic               sample;
  logic               advance;

  assign len_c = (len > MAX_LEN4) ? MAX_LEN4 : len;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode, datapath strobes and detector/status outputs.
  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    sample    = 1'b0;
    advance   = 1'b0;
    det_next  = 1'b0;
    det_in    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    // Detector must be held in reset while our own reset is asserted.
    det_reset = reset | (state == S_CLR);
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          load = 1'b1;
          if (len_c == 4'd0) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_CLR;
          end
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_CLR: begin
        if (cnt == 8'd1) begin
          state_nx = S_DRIVE;
        end else begin
          state_nx = S_CLR;
        end
      end
      S_DRIVE: begin
        det_next = 1'b1;
        det_in   = pat[MAX_LEN-1];
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        det_in = pat[MAX_LEN-1];
        if (cnt == GAP_LAST) begin
          state_nx = S_SAMPLE;
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_SAMPLE: begin
        det_in = pat[MAX_LEN-1];
        sample = 1'b1;
        // Lock-up takes priority over normal end of pattern.
        if (det_state == LOCK_CODE) begin
          state_nx = S_DONE;
        end else if (k == (len_q - 4'd1)) begin
          state_nx = S_DONE;
        end else begin
          advance  = 1'b1;
          state_nx = S_DRIVE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Dwell counter, restarted on every state change (times CLR and WAIT).
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (state_nx != state) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // Pattern/step capture and result accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat       <= '0;
      len_q     <= 4'd0;
      k         <= 4'd0;
      hit       <= 1'b0;
      hit_idx   <= 4'd0;
      hit_count <= 4'd0;
      locked    <= 1'b0;
    end else if (load) begin
      // Left-align so bit len-1 lands in the MSB and is sent first.
      pat       <= pattern << (MAX_LEN - 32'(len_c));
      len_q     <= len_c;
      k         <= 4'd0;
      hit       <= 1'b0;
      hit_idx   <= 4'd0;
      hit_count <= 4'd0;
      locked    <= 1'b0;
    end else begin
      if (sample) begin
        if (det_out) begin
          if (hit_count != 4'd15) begin
            hit_count <= hit_count + 4'd1;
          end
          if (!hit) begin
            hit     <= 1'b1;
            hit_idx <= k;
          end
        end
        if (det_state == LOCK_CODE) begin
          locked <= 1'b1;
        end
      end
      if (advance) begin
        k   <= k + 4'd1;
        pat <= {pat[MAX_LEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_seq_stepper.sv
// Testbench for seq_stepper: a small detector stand-in (detects "010",
// traps in state 6 after three consecutive 1s), directed and random runs,
// and a scoreboard whose expectations come from a history-based model.
module tb_seq_stepper;

  localparam int MAX_LEN = 8;
  localparam int GAP     = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = 8'd0;
  logic [3:0] len = 4'd0;
  logic [2:0] det_state;
  logic       det_out;
  logic       det_reset, det_in, det_next, busy, done, hit, locked;
  logic [3:0] hit_idx, hit_count;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       hit;
    int         idx;
    int         cnt;
    logic       locked;
    int         steps;
    int         rst_cycles;
    int         busy_cycles;
    logic [7:0] bits;
  } exp_t;

  exp_t q[$];

  seq_stepper #(.MAX_LEN(MAX_LEN), .GAP(GAP), .LOCK_CODE(3'd6)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .det_state(det_state), .det_out(det_out), .det_reset(det_reset),
    .det_in(det_in), .det_next(det_next), .busy(busy), .done(done),
    .hit(hit), .hit_idx(hit_idx), .hit_count(hit_count), .locked(locked)
  );

  always #5 clk = ~clk;

  // Detector stand-in: 0 START, 1 "0", 2 "01", 3 "010" (out), 4/5 runs of 1s, 6 trap.
  function automatic logic [2:0] det_step(logic [2:0] s, logic b);
    case (s)
      3'd0: return b ? 3'd4 : 3'd1;
      3'd1: return b ? 3'd2 : 3'd1;
      3'd2: return b ? 3'd5 : 3'd3;
      3'd3: return b ? 3'd2 : 3'd1;
      3'd4: return b ? 3'd5 : 3'd1;
      3'd5: return b ? 3'd6 : 3'd1;
      default: return 3'd6;
    endcase
  endfunction

  always @(posedge clk) begin
    if (det_reset) det_state <= 3'd0;
    else if (det_next) det_state <= det_step(det_state, det_in);
  end
  assign det_out = (det_state == 3'd3);

  // Reference: works on the bit history directly, not on detector states.
  function automatic exp_t model(logic [7:0] p, logic [3:0] l);
    exp_t e;
    int n;
    logic [7:0] b;
    n = (l > 4'd8) ? 8 : int'(l);
    e.hit = 1'b0; e.idx = 0; e.cnt = 0; e.locked = 1'b0; e.steps = 0; e.bits = 8'd0;
    b = 8'd0;
    for (int i = 0; i < n; i++) b[i] = p[n-1-i];
    e.bits = b;
    for (int i = 0; i < n; i++) begin
      e.steps = i + 1;
      if (i >= 2 && !b[i-2] && b[i-1] && !b[i]) begin
        if (e.cnt < 15) e.cnt++;
        if (!e.hit) begin e.hit = 1'b1; e.idx = i; end
      end
      if (i >= 2 && b[i-2] && b[i-1] && b[i]) begin
        e.locked = 1'b1;
        break;
      end
    end
    e.rst_cycles  = (n == 0) ? 0 : 2;
    e.busy_cycles = (n == 0) ? 1 : 3 + e.steps * (GAP + 2);
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts strobes per run and scores results on every done pulse.
  int nxt_cnt = 0, rst_cnt = 0, busy_cnt = 0;
  logic prev_next = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      nxt_cnt = 0; rst_cnt = 0; busy_cnt = 0; prev_next = 1'b0;
    end else begin
      if (det_next) begin
        chk("next_back_to_back", int'(prev_next), 0);
        if (q.size() > 0 && nxt_cnt < 8) chk("det_in_bit", int'(det_in), int'(q[0].bits[nxt_cnt]));
        nxt_cnt++;
      end
      prev_next = det_next;
      if (det_reset) rst_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending run at %0t", $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("hit", int'(hit), int'(e.hit));
          chk("hit_idx", int'(hit_idx), e.idx);
          chk("hit_count", int'(hit_count), e.cnt);
          chk("locked", int'(locked), int'(e.locked));
          chk("next_pulses", nxt_cnt, e.steps);
          chk("det_reset_cycles", rst_cnt, e.rst_cycles);
          chk("busy_cycles", busy_cnt, e.busy_cycles);
        end
        nxt_cnt = 0; rst_cnt = 0; busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic run(logic [7:0] p, logic [3:0] l, bit poke);
    wait_idle();
    @(posedge clk); #1;
    pattern = p; len = l; start = 1'b1;
    q.push_back(model(p, l));
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1; pattern = ~p; len = 4'd5;
      @(posedge clk); #1;
      start = 1'b0; pattern = 8'($urandom);
    end
    wait_idle();
  endtask

  initial begin
    int t, seen;
    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    chk("rst_det_reset", int'(det_reset), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_det_next", int'(det_next), 0);
    chk("rst_det_in", int'(det_in), 0);
    chk("rst_results", int'({hit, hit_idx, hit_count, locked}), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rel_det_reset", int'(det_reset), 0);
    chk("rel_busy", int'(busy), 0);

    run(8'b00000010, 4'd3, 1'b0);   // 0,1,0 -> hit at step 2
    run(8'b00010010, 4'd6, 1'b0);   // two overlapping-free hits
    run(8'b00011100, 4'd5, 1'b0);   // locks after third bit
    run(8'b01001001, 4'd7, 1'b1);   // second start / pattern change ignored
    run(8'b10101010, 4'd0, 1'b0);   // empty run
    run(8'b01001010, 4'd12, 1'b0);  // clamped to 8 bits

    // Reset during WAIT of step 1.
    wait_idle();
    @(posedge clk); #1;
    pattern = 8'b00001001; len = 4'd5; start = 1'b1;
    q.push_back(model(8'b00001001, 4'd5));
    @(posedge clk); #1 start = 1'b0;
    seen = 0; t = 0;
    while (seen < 2 && t < 200) begin
      @(negedge clk);
      if (det_next) seen++;
      t++;
    end
    chk("mid_reset_reach_step1", seen, 2);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_reset_busy", int'(busy), 0);
    chk("mid_reset_det_next", int'(det_next), 0);
    chk("mid_reset_done", int'(done), 0);
    chk("mid_reset_results", int'({hit, hit_idx, hit_count, locked}), 0);
    repeat (20) @(negedge clk);
    run(8'b00000010, 4'd3, 1'b0);

    for (int i = 0; i < 25; i++) begin
      run(8'($urandom), 4'($urandom_range(0, 15)), 1'b0);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
